// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control unit: main FSM, NZCV flag register and condition check.
// Every datapath select and gated write enable for the ADD/SUB/AND/ORR, LDR/STR and B subset comes from here.
module multicycle_control_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter int         STATE_W  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUControl,
    output logic [3:0]         Flags,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    state_t  state;
    state_t  next_state;
    logic [3:0] flags;

    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic       u_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       l_bit;
    logic       rd_is_pc;

    logic    dp_supported;
    alu_op_t dp_op;
    logic    dp_arith;
    logic    cond_ex;

    logic    pc_we;
    logic    ir_we;
    logic    reg_we;
    logic    mem_we;
    logic    adr_src;
    logic [1:0] result_src;
    logic    alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t alu_sel;

    // Register/immediate operand fields only matter to the datapath.
    logic unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign i_bit    = Instr[25];
    assign u_bit    = Instr[23];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];
    assign l_bit    = Instr[20];
    assign rd_is_pc = (Instr[15:12] == 4'hF);

    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        dp_supported = 1'b1;
        dp_op        = ALU_ADD;
        case (cmd)
            CMD_ADD: dp_op = ALU_ADD;
            CMD_SUB: dp_op = ALU_SUB;
            CMD_AND: dp_op = ALU_AND;
            CMD_ORR: dp_op = ALU_ORR;
            default: dp_supported = 1'b0;
        endcase
    end

    assign dp_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);

    // Condition is evaluated against the registered flags, never the live ALU flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Logic ops leave C and V alone; only arithmetic refreshes them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flags <= FLAG_RST;
        end else if (((state == EXECUTER) || (state == EXECUTEI)) && s_bit && cond_ex) begin
            flags[3:2] <= ALUFlags[3:2];
            if (dp_arith) begin
                flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        next_state = FETCH;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_sel    = ALU_ADD;
        case (state)
            FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op)
                    OP_MEM: next_state = MEMADR;
                    OP_BR:  next_state = BRANCH;
                    OP_DP: begin
                        if (!dp_supported) begin
                            next_state = FETCH;
                        end else if (i_bit) begin
                            next_state = EXECUTEI;
                        end else begin
                            next_state = EXECUTER;
                        end
                    end
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b  = 2'b01;
                alu_sel    = u_bit ? ALU_ADD : ALU_SUB;
                next_state = l_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                next_state = MEMWB;
            end
            // A load into R15 becomes a PC write instead of a register write.
            MEMWB: begin
                adr_src    = 1'b1;
                result_src = 2'b01;
                reg_we     = cond_ex & ~rd_is_pc;
                pc_we      = cond_ex & rd_is_pc;
                next_state = FETCH;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_we     = cond_ex;
                next_state = FETCH;
            end
            EXECUTER: begin
                alu_src_b  = 2'b00;
                alu_sel    = dp_op;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b  = 2'b01;
                alu_sel    = dp_op;
                next_state = ALUWB;
            end
            ALUWB: begin
                result_src = 2'b00;
                reg_we     = cond_ex & ~rd_is_pc;
                pc_we      = cond_ex & rd_is_pc;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_we      = cond_ex;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_MEM:  ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign RegSrc = {(op == OP_MEM) && !l_bit, (op == OP_BR)};

    // Reset suppresses every write so an abandoned instruction leaves no trace.
    assign PCWrite  = pc_we  & ~RST;
    assign IRWrite  = ir_we  & ~RST;
    assign RegWrite = reg_we & ~RST;
    assign MemWrite = mem_we & ~RST;

    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ALUControl = alu_sel;
    assign Flags      = flags;
    assign State      = STATE_W'(state);

endmodule
